// File: rtl/mcpu_bus_demux_pkg.sv
// Shared types and constants for the MCPU memory-port demux and its helpers.
package mcpu_bus_demux_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [31:0] ERR_DATA      = 32'hDEAD_BEEF;
    localparam logic [3:0]  IO_NIBBLE_DEF = 4'hF;
    localparam int unsigned TIMEOUT_DEF   = 16;
    localparam int unsigned CNT_W_DEF     = 5;

endpackage

// File: rtl/mcpu_bus_timeout.sv
// Wait-cycle counter for MCPU bus masters; flags when TIMEOUT-1 has been reached.
module mcpu_bus_timeout #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired_c
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign expired_c = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mcpu_bus_demux.sv
// Routes one CPU memory transaction to the data RAM (slave 0) or MMIO (slave 1),
// registers the returned read data and aborts with an error if no ack arrives.
module mcpu_bus_demux
    import mcpu_bus_demux_pkg::*;
#(
    parameter logic [3:0]  IO_NIBBLE = IO_NIBBLE_DEF,
    parameter int unsigned TIMEOUT   = TIMEOUT_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    output logic        cpu_err,
    output logic        s0_req,
    output logic        s1_req,
    output logic        s_we,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic [31:0] s0_rdata,
    input  logic [31:0] s1_rdata,
    input  logic        s0_ack,
    input  logic        s1_ack
);

    state_t      state_q, state_d;
    logic        sel_q, sel_d;
    logic [31:0] rdata_d;
    logic        ready_d, err_d;
    logic        s0_req_d, s1_req_d;
    logic        s_we_d;
    logic [31:0] s_addr_d, s_wdata_d;

    logic        sel_ack;
    logic [31:0] sel_rdata;
    logic        expired_c;

    // Only the latched target's ack/data matter; the other slave is ignored.
    assign sel_ack   = sel_q ? s1_ack : s0_ack;
    assign sel_rdata = sel_q ? s1_rdata : s0_rdata;

    mcpu_bus_timeout #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (state_q == IDLE),
        .en        ((state_q == WAIT) && !sel_ack),
        .expired_c (expired_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sel_q     <= 1'b0;
            cpu_rdata <= '0;
            cpu_ready <= 1'b0;
            cpu_err   <= 1'b0;
            s0_req    <= 1'b0;
            s1_req    <= 1'b0;
            s_we      <= 1'b0;
            s_addr    <= '0;
            s_wdata   <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            cpu_rdata <= rdata_d;
            cpu_ready <= ready_d;
            cpu_err   <= err_d;
            s0_req    <= s0_req_d;
            s1_req    <= s1_req_d;
            s_we      <= s_we_d;
            s_addr    <= s_addr_d;
            s_wdata   <= s_wdata_d;
        end
    end

    // cpu_ready/cpu_err are set on entry to DONE so they are high exactly in DONE.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        rdata_d   = cpu_rdata;
        ready_d   = 1'b0;
        err_d     = 1'b0;
        s0_req_d  = s0_req;
        s1_req_d  = s1_req;
        s_we_d    = s_we;
        s_addr_d  = s_addr;
        s_wdata_d = s_wdata;

        unique case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    sel_d     = (cpu_addr[31:28] == IO_NIBBLE);
                    s_we_d    = cpu_we;
                    s_addr_d  = cpu_addr;
                    s_wdata_d = cpu_wdata;
                    s0_req_d  = (cpu_addr[31:28] != IO_NIBBLE);
                    s1_req_d  = (cpu_addr[31:28] == IO_NIBBLE);
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                // An ack in the expiry cycle still counts as a normal completion.
                if (sel_ack) begin
                    s0_req_d = 1'b0;
                    s1_req_d = 1'b0;
                    if (!s_we) begin
                        rdata_d = sel_rdata;
                    end
                    ready_d = 1'b1;
                    state_d = DONE;
                end else if (expired_c) begin
                    s0_req_d = 1'b0;
                    s1_req_d = 1'b0;
                    rdata_d  = ERR_DATA;
                    ready_d  = 1'b1;
                    err_d    = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mcpu_bus_demux.sv
// Directed bench for mcpu_bus_demux: routing, read capture, timeout, races, reset.
module tb_mcpu_bus_demux;

    logic        clk;
    logic        rst_n;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        cpu_err;
    logic        s0_req;
    logic        s1_req;
    logic        s_we;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [31:0] s0_rdata;
    logic [31:0] s1_rdata;
    logic        s0_ack;
    logic        s1_ack;

    int checks = 0;
    int errors = 0;

    mcpu_bus_demux dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .cpu_err   (cpu_err),
        .s0_req    (s0_req),
        .s1_req    (s1_req),
        .s_we      (s_we),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s0_rdata  (s0_rdata),
        .s1_rdata  (s1_rdata),
        .s0_ack    (s0_ack),
        .s1_ack    (s1_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        tick();
        cpu_req   = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".rdata"}, cpu_rdata, 32'h0);
        chk({tag, ".ready"}, 32'(cpu_ready), 0);
        chk({tag, ".err"},   32'(cpu_err), 0);
        chk({tag, ".s0req"}, 32'(s0_req), 0);
        chk({tag, ".s1req"}, 32'(s1_req), 0);
        chk({tag, ".swe"},   32'(s_we), 0);
        chk({tag, ".saddr"}, s_addr, 32'h0);
        chk({tag, ".swdat"}, s_wdata, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        s0_rdata = '0; s1_rdata = '0; s0_ack = 1'b0; s1_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("rst");
        rst_n = 1'b1;
        tick();

        // RAM read, ack in the third WAIT cycle
        start(1'b0, 32'h0000_0010, 32'h0);
        chk("rd.saddr", s_addr, 32'h0000_0010);
        chk("rd.swe", 32'(s_we), 0);
        for (int i = 0; i < 3; i++) begin
            chk("rd.s0req", 32'(s0_req), 1);
            chk("rd.s1req", 32'(s1_req), 0);
            chk("rd.noready", 32'(cpu_ready), 0);
            if (i == 2) begin
                s0_ack = 1'b1; s0_rdata = 32'h1234_5678;
            end
            tick();
        end
        s0_ack = 1'b0; s0_rdata = '0;
        chk("rd.s0drop", 32'(s0_req), 0);
        chk("rd.ready", 32'(cpu_ready), 1);
        chk("rd.err", 32'(cpu_err), 0);
        chk("rd.rdata", cpu_rdata, 32'h1234_5678);
        tick();
        chk("rd.readyoff", 32'(cpu_ready), 0);

        // IO write, ack in the first WAIT cycle; rdata must not change
        start(1'b1, 32'hF000_0004, 32'hA5A5_A5A5);
        chk("wr.s1req", 32'(s1_req), 1);
        chk("wr.s0req", 32'(s0_req), 0);
        chk("wr.swdat", s_wdata, 32'hA5A5_A5A5);
        chk("wr.swe", 32'(s_we), 1);
        s1_ack = 1'b1; s1_rdata = 32'hFFFF_0000;
        tick();
        s1_ack = 1'b0; s1_rdata = '0;
        chk("wr.ready", 32'(cpu_ready), 1);
        chk("wr.rdata", cpu_rdata, 32'h1234_5678);
        chk("wr.s1drop", 32'(s1_req), 0);
        tick();

        // Timeout: s0 never acks
        start(1'b0, 32'h0000_0000, 32'h0);
        for (int i = 0; i < 16; i++) begin
            chk("to.s0req", 32'(s0_req), 1);
            chk("to.noready", 32'(cpu_ready), 0);
            tick();
        end
        chk("to.s0drop", 32'(s0_req), 0);
        chk("to.ready", 32'(cpu_ready), 1);
        chk("to.err", 32'(cpu_err), 1);
        chk("to.rdata", cpu_rdata, 32'hDEAD_BEEF);
        tick();
        chk("to.readyoff", 32'(cpu_ready), 0);
        chk("to.erroff", 32'(cpu_err), 0);

        // Wrong-slave ack is ignored
        start(1'b0, 32'hF000_0000, 32'h0);
        s0_ack = 1'b1; s0_rdata = 32'h0000_0111;
        tick();
        s0_ack = 1'b0; s0_rdata = '0;
        chk("ws.noready", 32'(cpu_ready), 0);
        chk("ws.s1req", 32'(s1_req), 1);
        tick();
        tick();
        s1_ack = 1'b1; s1_rdata = 32'hCAFE_0001;
        tick();
        s1_ack = 1'b0; s1_rdata = '0;
        chk("ws.ready", 32'(cpu_ready), 1);
        chk("ws.err", 32'(cpu_err), 0);
        chk("ws.rdata", cpu_rdata, 32'hCAFE_0001);
        tick();

        // Ack in the expiry cycle wins over the timeout
        start(1'b0, 32'hF000_0008, 32'h0);
        for (int i = 0; i < 16; i++) begin
            chk("race.s1req", 32'(s1_req), 1);
            if (i == 15) begin
                s1_ack = 1'b1; s1_rdata = 32'h0BAD_F00D;
            end
            tick();
        end
        s1_ack = 1'b0; s1_rdata = '0;
        chk("race.ready", 32'(cpu_ready), 1);
        chk("race.err", 32'(cpu_err), 0);
        chk("race.rdata", cpu_rdata, 32'h0BAD_F00D);
        tick();

        // Back-to-back with cpu_req held high: RAM then IO
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0020;
        tick();
        chk("b2b.s0req", 32'(s0_req), 1);
        chk("b2b.s1req0", 32'(s1_req), 0);
        cpu_addr = 32'hF000_0030;
        s0_ack = 1'b1; s0_rdata = 32'h1111_2222;
        tick();
        s0_ack = 1'b0; s0_rdata = '0;
        chk("b2b.ready1", 32'(cpu_ready), 1);
        chk("b2b.rdata1", cpu_rdata, 32'h1111_2222);
        chk("b2b.saddr1", s_addr, 32'h0000_0020);
        tick();
        chk("b2b.idle.ready", 32'(cpu_ready), 0);
        chk("b2b.idle.s1req", 32'(s1_req), 0);
        tick();
        cpu_req = 1'b0;
        chk("b2b.s1req", 32'(s1_req), 1);
        chk("b2b.s0req2", 32'(s0_req), 0);
        chk("b2b.saddr2", s_addr, 32'hF000_0030);
        s1_ack = 1'b1; s1_rdata = 32'h3333_4444;
        tick();
        s1_ack = 1'b0; s1_rdata = '0;
        chk("b2b.ready2", 32'(cpu_ready), 1);
        chk("b2b.rdata2", cpu_rdata, 32'h3333_4444);
        tick();

        // Asynchronous reset in the middle of WAIT
        start(1'b1, 32'h0000_0040, 32'h7777_8888);
        chk("mr.s0req", 32'(s0_req), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("mr");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("mr.idle", 32'(s0_req), 0);
        start(1'b0, 32'h0000_0050, 32'h0);
        chk("mr2.s0req", 32'(s0_req), 1);
        s0_ack = 1'b1; s0_rdata = 32'h55AA_55AA;
        tick();
        s0_ack = 1'b0; s0_rdata = '0;
        chk("mr2.ready", 32'(cpu_ready), 1);
        chk("mr2.rdata", cpu_rdata, 32'h55AA_55AA);
        chk("mr2.err", 32'(cpu_err), 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mcpu_bus_demux.md
Name: mcpu_bus_demux

Overview:
- Routes one multi-cycle CPU memory transaction to one of two targets: slave 0 (data RAM) or slave 1 (memory-mapped I/O). This is the fan-out counterpart of the 32-bit 2:1 datapath select.
- The slave's read data is registered and returned to the CPU.
- Sits between the MCPU control/datapath memory port and the RAM/IO blocks.
- A timeout guards against a slave that never acknowledges.

Parameters:
- IO_NIBBLE, 4'hF: cpu_addr[31:28] value that selects slave 1. Every other value selects slave 0.
- TIMEOUT, 16: number of wait cycles without an ack before the transaction aborts (minimum 2).
- CNT_W, 5: timeout counter width. Must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- cpu_req  in  1  transaction request. Sampled only in IDLE.
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  write data
- cpu_rdata  out  32  registered read data
- cpu_ready  out  1  one-cycle completion pulse
- cpu_err  out  1  one-cycle timeout pulse, coincident with cpu_ready
- s0_req, s1_req  out  1  per-slave request. Held high until the matching ack.
- s_we  out  1  shared latched write enable
- s_addr  out  32  shared latched address
- s_wdata  out  32  shared latched write data
- s0_rdata, s1_rdata  in  32  slave read data. Valid in the cycle its ack is high.
- s0_ack, s1_ack  in  1  slave completion strobe

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE. All outputs are 0: cpu_rdata, cpu_ready, cpu_err, s0_req, s1_req, s_we, s_addr, s_wdata, and the timeout counter.
- States: IDLE, WAIT, DONE.
- IDLE, cpu_req=1:
  - Latch cpu_we/addr/wdata into s_we/s_addr/s_wdata.
  - Latch sel = (cpu_addr[31:28]==IO_NIBBLE).
  - Clear the counter.
  - Next state WAIT.
  - The slave request asserts on the following cycle: s1_req when sel=1, otherwise s0_req. Never both.
- WAIT, selected ack=1:
  - Drop the request.
  - If s_we=0, capture the selected slave's rdata into cpu_rdata.
  - Next state DONE.
- WAIT, no ack:
  - Increment the counter.
  - When counter == TIMEOUT-1 with no ack: drop the request, set a pending-error flag, next state DONE. cpu_rdata is set to 32'hDEAD_BEEF.
- WAIT, ack from the non-selected slave: ignored. It does not count as completion and does not reset the counter.
- DONE:
  - cpu_ready=1 for exactly this cycle.
  - cpu_err=1 for this cycle if the pending-error flag is set; clear the flag.
  - Next state IDLE.
- cpu_req is ignored outside IDLE. Minimum turnaround is req cycle → WAIT ≥1 cycle → DONE, so ready arrives no earlier than 2 cycles after req.
- Back-to-back: cpu_req held high in the IDLE cycle after DONE starts a new transaction immediately.
- Write completion: cpu_rdata keeps its previous value.
- Ack arriving in the same cycle the count hits TIMEOUT-1: the ack wins (normal completion, no error).
- Reset mid-transaction: immediate return to IDLE with all outputs cleared. An in-flight slave request is abandoned.
- s_addr, s_we and s_wdata stay stable from the WAIT entry until the next accepted request.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'd0, WAIT=2'd1, DONE=2'd2
  - ERR_DATA=32'hDEAD_BEEF
  - IO_NIBBLE default
- One natural sub-module: mcpu_bus_timeout.
  - A CNT_W counter with clear/enable inputs and an expired output.
  - Reusable by other MCPU bus masters.

Test Plan:
- RAM read: cpu_req with addr=32'h0000_0010, we=0; s0 acks 3 cycles later with rdata=32'h1234_5678.
  - s0_req high for exactly 3 cycles, s1_req stays 0.
  - cpu_ready pulses 1 cycle later with cpu_rdata=32'h1234_5678 and cpu_err=0.
- IO write: addr=32'hF000_0004, we=1, wdata=32'hA5A5_A5A5; s1 acks after 1 cycle.
  - s1_req high, s_wdata=32'hA5A5_A5A5.
  - cpu_ready pulses, cpu_rdata unchanged.
- Timeout: addr=32'h0000_0000 with s0_ack never asserted.
  - s0_req drops after 16 cycles.
  - cpu_ready=cpu_err=1 for one cycle, cpu_rdata=32'hDEAD_BEEF.
- Wrong-slave and race cases:
  - s1 target; s0_ack pulses in WAIT → ignored, transaction continues.
  - Separately, s1_ack arrives exactly at counter 15 → normal completion, cpu_err=0.
- Back-to-back: cpu_req held high across two transactions (RAM then IO), each acked immediately.
  - Two cpu_ready pulses, each 2 cycles after its accept.
  - Correct per-slave routing for each.
- Reset mid-WAIT: assert rst_n=0 asynchronously between clock edges while s0_req=1.
  - All outputs are 0 immediately.
  - After release, a new read completes normally.
